// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register built as a two-entry skid buffer.
// Ports: clk_i/rst_i (sync, active-high), flush_i drops all held entries,
//   in_valid_i/in_ready_o/in_data_i/in_ctrl_i upstream handshake and payload,
//   out_valid_o/out_ready_i/out_data_o/out_ctrl_o downstream handshake and payload,
//   stall_cnt_o saturating count of back-pressured cycles.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t main_q;
  entry_t skid_q;
  logic   in_fire;
  logic   out_fire;

  // Ready depends only on the skid flop, so out_ready_i never
  // reaches in_ready_o combinationally.
  assign in_ready_o  = ~skid_q.v;
  assign out_valid_o = main_q.v;
  assign out_data_o  = main_q.data;
  assign out_ctrl_o  = main_q.ctrl;

  assign in_fire  = in_valid_i & ~skid_q.v;
  assign out_fire = main_q.v & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      // Data is kept; clearing ctrl keeps the bubble harmless.
      main_q.v    <= 1'b0;
      main_q.ctrl <= '0;
      skid_q.v    <= 1'b0;
      skid_q.ctrl <= '0;
    end else if (out_fire) begin
      if (skid_q.v) begin
        main_q      <= skid_q;
        skid_q.v    <= 1'b0;
        skid_q.ctrl <= '0;
      end else if (in_fire) begin
        main_q <= {1'b1, in_data_i, in_ctrl_i};
      end else begin
        main_q.v    <= 1'b0;
        main_q.ctrl <= '0;
      end
    end else if (in_fire) begin
      // Main empty implies skid empty, so the entry goes to main;
      // otherwise main is stuck and the entry parks in skid.
      if (!main_q.v) begin
        main_q <= {1'b1, in_data_i, in_ctrl_i};
      end else begin
        skid_q <= {1'b1, in_data_i, in_ctrl_i};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (main_q.v && !out_ready_i
                 && stall_cnt_o != CNT_MAX) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vector table plus randomised scoreboard
// for the ex_mem_stage skid buffer.
module tb_ex_mem_stage;

  localparam int DW = 32;
  localparam int CW = 5;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic          out_valid, out_ready;
  logic [NW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_ctrl_i   (in_ctrl),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_ctrl_o  (out_ctrl),
    .stall_cnt_o (stall_cnt)
  );

  typedef struct {
    logic          rst;
    logic          flush;
    logic          iv;
    logic [DW-1:0] id;
    logic [CW-1:0] ic;
    logic          ordy;
    logic          ov;
    logic          ir;
    logic [DW-1:0] od;
    logic [CW-1:0] oc;
    logic [NW-1:0] sc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(
      input logic r, input logic f, input logic iv,
      input logic [DW-1:0] id, input logic [CW-1:0] ic,
      input logic ordy, input logic ov, input logic ir,
      input logic [DW-1:0] od, input logic [CW-1:0] oc,
      input logic [NW-1:0] sc);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ic = ic;
    v.ordy = ordy; v.ov = ov; v.ir = ir; v.od = od;
    v.oc = oc; v.sc = sc;
    return v;
  endfunction

  // Scoreboard model state
  logic [DW+CW-1:0] q[$];
  logic [NW-1:0]    m_cnt;
  logic             m_in_fire, m_out_fire;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_ctrl = '0; out_ready = 1'b0;

    //          rst fl iv id     ic     rdy ov ir od     oc     sc
    // reset
    vecs.push_back(mk(1,0,0,32'h0,5'h00,0, 0,1,32'h0,5'h00,2'd0));
    // stream 1,2,3 then drain
    vecs.push_back(mk(0,0,1,32'h1,5'h03,1, 1,1,32'h1,5'h03,2'd0));
    vecs.push_back(mk(0,0,1,32'h2,5'h03,1, 1,1,32'h2,5'h03,2'd0));
    vecs.push_back(mk(0,0,1,32'h3,5'h03,1, 1,1,32'h3,5'h03,2'd0));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,1, 0,1,32'h3,5'h00,2'd0));
    // back-pressure: A in main, B in skid, release
    vecs.push_back(mk(0,0,1,32'hA,5'h05,0, 1,1,32'hA,5'h05,2'd0));
    vecs.push_back(mk(0,0,1,32'hB,5'h06,0, 1,0,32'hA,5'h05,2'd1));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,0, 1,0,32'hA,5'h05,2'd2));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,1, 1,1,32'hB,5'h06,2'd2));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,1, 0,1,32'hB,5'h00,2'd2));
    // flush with both entries full, ctrl all ones
    vecs.push_back(mk(0,0,1,32'hC,5'h1F,0, 1,1,32'hC,5'h1F,2'd2));
    vecs.push_back(mk(0,0,1,32'hD,5'h1F,0, 1,0,32'hC,5'h1F,2'd3));
    vecs.push_back(mk(0,1,1,32'hE,5'h1F,0, 0,1,32'hC,5'h00,2'd3));
    // flush drops an input that would otherwise be accepted
    vecs.push_back(mk(0,0,1,32'hF,5'h02,0, 1,1,32'hF,5'h02,2'd3));
    vecs.push_back(mk(0,1,1,32'h10,5'h04,0,0,1,32'hF,5'h00,2'd3));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,1, 0,1,32'hF,5'h00,2'd3));
    // stall counter saturation at 3
    vecs.push_back(mk(1,0,0,32'h0,5'h00,0, 0,1,32'h0,5'h00,2'd0));
    vecs.push_back(mk(0,0,1,32'h7,5'h01,0, 1,1,32'h7,5'h01,2'd0));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,0, 1,1,32'h7,5'h01,2'd1));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,0, 1,1,32'h7,5'h01,2'd2));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,0, 1,1,32'h7,5'h01,2'd3));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,0, 1,1,32'h7,5'h01,2'd3));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,0, 1,1,32'h7,5'h01,2'd3));
    // reset with skid full, then fresh entry 5
    vecs.push_back(mk(0,0,1,32'h8,5'h01,0, 1,0,32'h7,5'h01,2'd3));
    vecs.push_back(mk(1,0,1,32'h9,5'h01,0, 0,1,32'h0,5'h00,2'd0));
    vecs.push_back(mk(0,0,1,32'h5,5'h01,0, 1,1,32'h5,5'h01,2'd0));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,1, 0,1,32'h5,5'h00,2'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; flush = vecs[i].flush;
      in_valid = vecs[i].iv; in_data = vecs[i].id;
      in_ctrl = vecs[i].ic; out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk("out_valid", i, 64'(out_valid), 64'(vecs[i].ov));
      chk("in_ready",  i, 64'(in_ready),  64'(vecs[i].ir));
      chk("out_data",  i, 64'(out_data),  64'(vecs[i].od));
      chk("out_ctrl",  i, 64'(out_ctrl),  64'(vecs[i].oc));
      chk("stall_cnt", i, 64'(stall_cnt), 64'(vecs[i].sc));
    end

    // Randomised scoreboard
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    q.delete();
    m_cnt = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      rst = 1'b0;
      chk("rnd_out_valid", c, 64'(out_valid), 64'(q.size() > 0));
      chk("rnd_in_ready",  c, 64'(in_ready),  64'(q.size() < 2));
      chk("rnd_stall_cnt", c, 64'(stall_cnt), 64'(m_cnt));
      if (q.size() > 0)
        chk("rnd_payload", c, 64'({out_data, out_ctrl}), 64'(q[0]));
      else
        chk("rnd_bubble_ctrl", c, 64'(out_ctrl), 64'(0));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      in_data   = $urandom;
      in_ctrl   = CW'($urandom);
      m_in_fire  = in_valid && (q.size() < 2);
      m_out_fire = out_ready && (q.size() > 0);
      @(posedge clk);
      if ((q.size() > 0) && !out_ready && (m_cnt != 2'd3))
        m_cnt = m_cnt + 1'b1;
      if (m_out_fire) void'(q.pop_front());
      if (flush) q.delete();
      else if (m_in_fire) q.push_back({in_data, in_ctrl});
    end

    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_W, default 32: payload data width (ALU result, store data, branch target packed by instantiator).
REQ-002 Parameter CTRL_W, default 5: control-bit width (Branch, MemRead, MemtoReg, MemWrite, RegWrite packed by instantiator).
REQ-003 Parameter CNT_W, default 16: stall-counter width.
REQ-004 Port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_i  input  1  synchronous, active-high reset.
REQ-006 Port flush_i  input  1  discard all held entries (branch mispredict / exception).
REQ-007 Port in_valid_i  input  1  upstream (EX) entry valid.
REQ-008 Port in_ready_o  output  1  stage can accept an entry; driven directly from a flop.
REQ-009 Port in_data_i  input  DATA_W  upstream payload.
REQ-010 Port in_ctrl_i  input  CTRL_W  upstream control bits.
REQ-011 Port out_valid_o  output  1  downstream (MEM) entry valid.
REQ-012 Port out_ready_i  input  1  downstream accepts the entry.
REQ-013 Port out_data_o  output  DATA_W  downstream payload.
REQ-014 Port out_ctrl_o  output  CTRL_W  downstream control bits.
REQ-015 Port stall_cnt_o  output  CNT_W  count of back-pressured cycles.

Function
REQ-016 Storage SHALL be two entries: main (drives outputs) and skid; each has a valid bit, data and ctrl.
REQ-017 Input transfer SHALL occur when in_valid_i && in_ready_o; output transfer when out_valid_o && out_ready_i.
REQ-018 in_ready_o SHALL equal NOT skid.valid (registered, no combinational path from out_ready_i).
REQ-019 Input transfer with main empty, or main transferring out this cycle with skid empty: entry SHALL load into main; latency in->out exactly 1 cycle.
REQ-020 Input transfer with main full and not transferring out: entry SHALL load into skid.
REQ-021 Output transfer with skid valid: skid SHALL move to main, skid becomes empty; a simultaneous input is impossible (in_ready_o=0).
REQ-022 Output transfer with skid empty and no input transfer: main.valid SHALL clear.
REQ-023 Entries SHALL leave in arrival order; no entry duplicated or dropped except by flush/reset.
REQ-024 out_ctrl_o SHALL be all-zero whenever out_valid_o=0 (ctrl register cleared on drain), so a bubble never asserts MemWrite/RegWrite.
REQ-025 out_data_o SHALL hold its last value when main drains; undefined-free (never X after reset).
REQ-026 flush_i=1 SHALL, at that edge, clear both valid bits and both ctrl registers; the same-cycle input is dropped; in_ready_o=1 next cycle.
REQ-027 Priority SHALL be rst_i > flush_i > normal transfer.
REQ-028 stall_cnt_o SHALL increment by 1 on each edge where out_valid_o=1 && out_ready_i=0, saturating at 2^CNT_W-1; flush does not clear it.
REQ-029 With out_ready_i held 1, the stage SHALL sustain one transfer per cycle indefinitely.

Reset
REQ-030 rst_i=1 at an edge SHALL set out_valid_o=0, skid.valid=0, in_ready_o=1, out_ctrl_o=0, out_data_o=0, stall_cnt_o=0.
REQ-031 Reset asserted mid-operation SHALL discard held entries with no partial output; first post-reset input appears 1 cycle after acceptance.

Verification
REQ-032 Stream: out_ready_i=1, inputs data 0x1,0x2,0x3 on consecutive cycles -> out_data_o 0x1,0x2,0x3 one cycle later each, in_ready_o stays 1.
REQ-033 Back-pressure: main holds 0xA, out_ready_i=0, input 0xB -> in_ready_o=0 next cycle; release out_ready_i -> 0xA then 0xB, in_ready_o=1 after 0xB enters main.
REQ-034 Flush with both entries full (ctrl 5'b11111) -> next cycle out_valid_o=0, out_ctrl_o=0, in_ready_o=1; same-cycle input absent from output.
REQ-035 Stall counter: CNT_W=2, out_valid_o=1, out_ready_i=0 for 5 cycles -> stall_cnt_o 1,2,3,3,3.
REQ-036 Reset during back-pressure with skid full -> next cycle all REQ-030 values; new input 0x5 appears on out_data_o one cycle after acceptance.
REQ-037 Random valid/ready scoreboard (10k cycles, random flush 1%) -> output sequence equals input sequence minus flushed entries, out_ctrl_o=0 whenever out_valid_o=0.
